// File: rtl/clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl
//
// Programmable, run-time reconfigurable clock-divider controller. A divide
// counter runs from 0 up to cur_max; each time it reaches cur_max a half-period
// boundary occurs, o_tick pulses and o_sclk toggles. Runs are continuous or a
// burst of a fixed number of ticks, and can be stopped at the next boundary.
// New divide values arrive over a valid/ready handshake. While running they are
// held pending and take effect only on a boundary, so o_sclk never glitches.
//
// Ports:
//   i_clk         system clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_cfg_valid   new divide value offered on i_cfg_max
//   o_cfg_ready   controller can accept i_cfg_max (registered)
//   i_cfg_max     half-period minus one, in i_clk cycles
//   i_start       single-cycle start request (IDLE only)
//   i_stop        single-cycle stop request (RUN only)
//   i_burst_len   ticks to run, 0 = continuous; sampled with i_start
//   o_sclk        divided clock (registered)
//   o_tick        one-cycle pulse on every o_sclk half-period boundary
//   o_busy        controller is not IDLE
//   o_done        one-cycle pulse when a burst or a stop completes
// -----------------------------------------------------------------------------
module clk_div_ctrl #(
    parameter int          CNT_W   = 32,
    parameter int          BURST_W = 16,
    parameter int unsigned DEF_MAX = 32'd1000000
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_cfg_valid,
    output logic               o_cfg_ready,
    input  logic [CNT_W-1:0]   i_cfg_max,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic [BURST_W-1:0] i_burst_len,
    output logic               o_sclk,
    output logic               o_tick,
    output logic               o_busy,
    output logic               o_done
);

    localparam logic [CNT_W-1:0]   CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [BURST_W-1:0] BCNT_ZERO = {BURST_W{1'b0}};
    localparam logic [BURST_W-1:0] BCNT_ONE  = {{(BURST_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   DEF_MAX_C = CNT_W'(DEF_MAX);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [BURST_W-1:0]   r_bcnt;
    logic [CNT_W-1:0]     r_cur_max;
    logic [CNT_W-1:0]     r_pend;
    logic                 r_pend_v;
    logic                 r_sclk;
    logic                 r_tick;
    logic                 r_done;
    logic                 r_busy;
    logic                 r_cfg_ready;

    state_t               w_state_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [BURST_W-1:0]   w_bcnt_nxt;
    logic [CNT_W-1:0]     w_cur_max_nxt;
    logic [CNT_W-1:0]     w_pend_nxt;
    logic                 w_pend_v_nxt;
    logic                 w_sclk_nxt;
    logic                 w_tick_nxt;
    logic                 w_done_nxt;
    logic                 w_xfer;
    logic                 w_boundary;
    logic                 w_run_end;

    // A transfer needs the registered ready; ready is only ever low while a
    // value is pending, so a transfer and an unapplied pending value never
    // coexist.
    assign w_xfer     = i_cfg_valid & r_cfg_ready;
    assign w_boundary = (r_cnt == r_cur_max);
    // Run ends on this boundary if a stop is pending or the burst count expires.
    assign w_run_end  = w_boundary &&
                        ((r_state == ST_STOPPING) || (r_bcnt == BCNT_ONE));

    // Next-state, counter, burst, configuration and output decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bcnt_nxt    = r_bcnt;
        w_cur_max_nxt = r_cur_max;
        w_pend_nxt    = r_pend;
        w_pend_v_nxt  = r_pend_v;
        w_sclk_nxt    = r_sclk;
        w_tick_nxt    = 1'b0;
        w_done_nxt    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt    = CNT_ZERO;
                w_sclk_nxt   = 1'b0;
                w_pend_v_nxt = 1'b0;
                // The IDLE-side write lands before the run starts, so a write
                // together with start is used by that run.
                if (w_xfer) begin
                    w_cur_max_nxt = i_cfg_max;
                end else begin
                    w_cur_max_nxt = r_cur_max;
                end
                // Stop dominates a simultaneous start.
                if (i_start && !i_stop) begin
                    w_state_nxt = ST_RUN;
                    w_bcnt_nxt  = i_burst_len;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_RUN, ST_STOPPING: begin
                if (w_boundary) begin
                    w_cnt_nxt  = CNT_ZERO;
                    w_tick_nxt = 1'b1;
                    if (r_bcnt != BCNT_ZERO) begin
                        w_bcnt_nxt = r_bcnt - BCNT_ONE;
                    end else begin
                        w_bcnt_nxt = BCNT_ZERO;
                    end
                    // A pending value is applied here; a value accepted on this
                    // same edge waits for the following boundary.
                    if (r_pend_v) begin
                        w_cur_max_nxt = r_pend;
                        w_pend_v_nxt  = 1'b0;
                    end else if (w_xfer) begin
                        w_pend_nxt   = i_cfg_max;
                        w_pend_v_nxt = 1'b1;
                    end else begin
                        w_pend_v_nxt = 1'b0;
                    end

                    if (w_run_end) begin
                        w_state_nxt = ST_IDLE;
                        w_sclk_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_bcnt_nxt  = BCNT_ZERO;
                        // Anything accepted on the exit edge goes straight in.
                        if (w_xfer) begin
                            w_cur_max_nxt = i_cfg_max;
                        end else begin
                            w_cur_max_nxt = (r_pend_v) ? r_pend : r_cur_max;
                        end
                        w_pend_v_nxt = 1'b0;
                    end else begin
                        w_sclk_nxt = ~r_sclk;
                        if ((r_state == ST_RUN) && i_stop) begin
                            w_state_nxt = ST_STOPPING;
                        end else begin
                            w_state_nxt = r_state;
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                    if (w_xfer) begin
                        w_pend_nxt   = i_cfg_max;
                        w_pend_v_nxt = 1'b1;
                    end else begin
                        w_pend_v_nxt = r_pend_v;
                    end
                    if ((r_state == ST_RUN) && i_stop) begin
                        w_state_nxt = ST_STOPPING;
                    end else begin
                        w_state_nxt = r_state;
                    end
                end
            end

            default: begin
                w_state_nxt  = ST_IDLE;
                w_cnt_nxt    = CNT_ZERO;
                w_bcnt_nxt   = BCNT_ZERO;
                w_pend_v_nxt = 1'b0;
                w_sclk_nxt   = 1'b0;
            end
        endcase
    end

    // State, datapath and registered-output update.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= CNT_ZERO;
            r_bcnt      <= BCNT_ZERO;
            r_cur_max   <= DEF_MAX_C;
            r_pend      <= CNT_ZERO;
            r_pend_v    <= 1'b0;
            r_sclk      <= 1'b0;
            r_tick      <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_cfg_ready <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bcnt      <= w_bcnt_nxt;
            r_cur_max   <= w_cur_max_nxt;
            r_pend      <= w_pend_nxt;
            r_pend_v    <= w_pend_v_nxt;
            r_sclk      <= w_sclk_nxt;
            r_tick      <= w_tick_nxt;
            r_done      <= w_done_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_cfg_ready <= ~w_pend_v_nxt;
        end
    end

    assign o_sclk      = r_sclk;
    assign o_tick      = r_tick;
    assign o_done      = r_done;
    assign o_busy      = r_busy;
    assign o_cfg_ready = r_cfg_ready;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_div_ctrl
//
// Directed bench for clk_div_ctrl. Inputs are driven 1 ns after each rising
// edge and outputs are checked at that same point. DEF_MAX is reduced so the
// post-reset default divide can be observed in a short run.
// -----------------------------------------------------------------------------
module tb_clk_div_ctrl;

    localparam int          CNT_W   = 32;
    localparam int          BURST_W = 16;
    localparam int unsigned DEF_MAX = 32'd6;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [CNT_W-1:0]   cfg_max;
    logic               start;
    logic               stop;
    logic [BURST_W-1:0] burst_len;
    logic               sclk;
    logic               tick;
    logic               busy;
    logic               done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clk_div_ctrl #(
        .CNT_W   (CNT_W),
        .BURST_W (BURST_W),
        .DEF_MAX (DEF_MAX)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_cfg_valid (cfg_valid),
        .o_cfg_ready (cfg_ready),
        .i_cfg_max   (cfg_max),
        .i_start     (start),
        .i_stop      (stop),
        .i_burst_len (burst_len),
        .o_sclk      (sclk),
        .o_tick      (tick),
        .o_busy      (busy),
        .o_done      (done)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic outs(input string tag, input int e_sclk, input int e_tick,
                        input int e_done, input int e_busy);
        chk({tag, ".sclk"}, int'(sclk), e_sclk);
        chk({tag, ".tick"}, int'(tick), e_tick);
        chk({tag, ".done"}, int'(done), e_done);
        chk({tag, ".busy"}, int'(busy), e_busy);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_max   = 32'd0;
        start     = 1'b0;
        stop      = 1'b0;
        burst_len = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        outs("rst", 0, 0, 0, 0);
        chk("rst.ready", int'(cfg_ready), 1);
        rst_n = 1'b1;
        step;

        // Continuous run at cur_max=3: tick every 4 cycles, sclk period 8.
        cfg_valid = 1'b1; cfg_max = 32'd3;
        step;
        cfg_valid = 1'b0;
        chk("t1.idle_ready", int'(cfg_ready), 1);
        chk("t1.idle_busy", int'(busy), 0);
        start = 1'b1; burst_len = 16'd0;
        step;
        start = 1'b0;
        outs("t1.e0", 0, 0, 0, 1);
        for (int k = 1; k <= 16; k++) begin
            step;
            outs("t1.run", (k / 4) % 2, (k % 4 == 0) ? 1 : 0, 0, 1);
        end

        // Mid-half-period reconfigure to cur_max=1.
        step;
        outs("t2.pre", 0, 0, 0, 1);
        cfg_valid = 1'b1; cfg_max = 32'd1;
        step;
        cfg_valid = 1'b0;
        chk("t2.ready_low_a", int'(cfg_ready), 0);
        outs("t2.xfer", 0, 0, 0, 1);
        step;
        chk("t2.ready_low_b", int'(cfg_ready), 0);
        outs("t2.wait", 0, 0, 0, 1);
        step;
        chk("t2.ready_high", int'(cfg_ready), 1);
        outs("t2.apply", 1, 1, 0, 1);
        for (int k = 1; k <= 4; k++) begin
            step;
            outs("t2.fast", ((k / 2) % 2 == 0) ? 1 : 0, (k % 2 == 0) ? 1 : 0, 0, 1);
        end

        // Stop while sclk=1: forced low on the ending boundary.
        stop = 1'b1;
        step;
        stop = 1'b0;
        outs("t3.stopping", 1, 0, 0, 1);
        step;
        outs("t3.done", 0, 1, 1, 0);
        chk("t3.ready", int'(cfg_ready), 1);
        step;
        outs("t3.idle", 0, 0, 0, 0);

        // Start and stop together in IDLE: nothing happens.
        start = 1'b1; stop = 1'b1;
        step;
        start = 1'b0; stop = 1'b0;
        outs("t4.startstop", 0, 0, 0, 0);
        step;
        outs("t4.still_idle", 0, 0, 0, 0);

        // Burst of 5 at cur_max=2, configured in the start cycle.
        cfg_valid = 1'b1; cfg_max = 32'd2; start = 1'b1; burst_len = 16'd5;
        step;
        cfg_valid = 1'b0; start = 1'b0; burst_len = 16'd0;
        outs("t5.e0", 0, 0, 0, 1);
        for (int k = 1; k <= 17; k++) begin
            step;
            outs("t5.burst",
                 (k < 15) ? ((k / 3) % 2) : 0,
                 (k <= 15 && k % 3 == 0) ? 1 : 0,
                 (k == 15) ? 1 : 0,
                 (k < 15) ? 1 : 0);
        end

        // cur_max=4, stop one cycle after a boundary with sclk=0.
        cfg_valid = 1'b1; cfg_max = 32'd4; start = 1'b1;
        step;
        cfg_valid = 1'b0; start = 1'b0;
        outs("t6.e0", 0, 0, 0, 1);
        for (int k = 1; k <= 10; k++) begin
            step;
            outs("t6.run", (k / 5) % 2, (k % 5 == 0) ? 1 : 0, 0, 1);
        end
        stop = 1'b1;
        step;
        stop = 1'b0;
        outs("t6.stop", 0, 0, 0, 1);
        for (int k = 12; k <= 14; k++) begin
            step;
            outs("t6.stopping", 0, 0, 0, 1);
        end
        step;
        outs("t6.done", 0, 1, 1, 0);
        step;
        outs("t6.idle", 0, 0, 0, 0);
        start = 1'b1;
        step;
        start = 1'b0;
        outs("t6.restart", 0, 0, 0, 1);
        for (int k = 1; k <= 5; k++) begin
            step;
            outs("t6.rerun", (k == 5) ? 1 : 0, (k == 5) ? 1 : 0, 0, 1);
        end
        stop = 1'b1;
        step;
        stop = 1'b0;
        outs("t6.stop2", 1, 0, 0, 1);
        for (int k = 7; k <= 9; k++) begin
            step;
            outs("t6.stopping2", 1, 0, 0, 1);
        end
        step;
        outs("t6.done2", 0, 1, 1, 0);

        // cur_max=0: tick held high, sclk toggles every cycle; then reset.
        cfg_valid = 1'b1; cfg_max = 32'd0; start = 1'b1;
        step;
        cfg_valid = 1'b0; start = 1'b0;
        outs("t7.e0", 0, 0, 0, 1);
        for (int k = 1; k <= 6; k++) begin
            step;
            outs("t7.run", k % 2, 1, 0, 1);
        end
        #2 rst_n = 1'b0;
        #1;
        outs("t7.rst", 0, 0, 0, 0);
        chk("t7.rst_ready", int'(cfg_ready), 1);
        #2 rst_n = 1'b1;

        // After reset cur_max is DEF_MAX (6): first tick 7 cycles after start.
        start = 1'b1;
        step;
        start = 1'b0;
        outs("t8.e0", 0, 0, 0, 1);
        for (int k = 1; k <= 7; k++) begin
            step;
            outs("t8.def", (k == 7) ? 1 : 0, (k == 7) ? 1 : 0, 0, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
